// File: rtl/branch_predict_if.sv
// branch_predict_if: fetch/execute/flush signal bundle for branch_predict; stat ports only when BP_STATS_EN is defined
interface branch_predict_if;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic        ex_br_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    modport master (
        output f_pc, ex_valid, ex_pc, ex_opcode, ex_br_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, flush, redirect_pc, stat_branches, stat_mispredicts
    );
    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_opcode, ex_br_taken, ex_target, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, flush, redirect_pc, stat_branches, stat_mispredicts
    );
`else
    modport master (
        output f_pc, ex_valid, ex_pc, ex_opcode, ex_br_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, flush, redirect_pc
    );
    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_opcode, ex_br_taken, ex_target, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, flush, redirect_pc
    );
`endif
endinterface

// File: rtl/branch_predict.sv
// branch_predict: 2-bit counter BHT + direct-mapped BTB with registered mispredict flush; BP_STATS_EN adds resolution counters
module branch_predict #(
    parameter int  ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input logic             clk,
    input logic             rst_n,
    branch_predict_if.slave bp
);
    localparam int         TAG_W   = 30 - IDX_W;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic             f_hit, e_hit, is_br, is_jmp, act_taken, mispred, accept;
    logic [1:0]       ctr_nxt;

    assign f_idx            = bp.f_pc[IDX_W+1:2];
    assign f_hit            = valid_q[f_idx] && tag_q[f_idx] == bp.f_pc[31:IDX_W+2];
    assign bp.f_pred_taken  = f_hit && ctr_q[f_idx][1];
    assign bp.f_pred_target = bp.f_pred_taken ? tgt_q[f_idx] : bp.f_pc + 32'd4;

    assign e_idx     = bp.ex_pc[IDX_W+1:2];
    assign e_hit     = valid_q[e_idx] && tag_q[e_idx] == bp.ex_pc[31:IDX_W+2];
    assign is_br     = bp.ex_opcode == OP_BR;
    assign is_jmp    = bp.ex_opcode == OP_JAL || bp.ex_opcode == OP_JALR;
    assign act_taken = is_jmp || (is_br && bp.ex_br_taken);
    assign mispred   = bp.ex_pred_taken != act_taken || (act_taken && bp.ex_pred_target != bp.ex_target);
    // the cycle after a mispredict carries a wrong-path instruction, so it is ignored entirely
    assign accept    = bp.ex_valid && !bp.flush;

    // saturating counter step; a taken branch that misses allocates a fresh weakly-taken entry
    always_comb begin
        ctr_nxt = is_jmp ? 2'b11
                : act_taken ? (e_hit ? ctr_q[e_idx] + {1'b0, ctr_q[e_idx] != 2'b11} : 2'b10)
                : ctr_q[e_idx] - {1'b0, ctr_q[e_idx] != 2'b00};
    end

    // valid bits and counters: train on taken, decay on hit not-taken branch, drop aliasing non-control hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (accept) begin
            if (act_taken) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= ctr_nxt;
            end else if (e_hit && is_br) begin
                ctr_q[e_idx]   <= ctr_nxt;
            end else if (e_hit && !is_jmp) begin
                valid_q[e_idx] <= 1'b0;
            end
        end
    end

    // tag and target arrays are qualified by valid_q, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept && act_taken) begin
            tag_q[e_idx] <= bp.ex_pc[31:IDX_W+2];
            tgt_q[e_idx] <= bp.ex_target;
        end
    end

    // one-cycle flush pulse with the corrected next PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.flush       <= 1'b0;
            bp.redirect_pc <= '0;
        end else begin
            bp.flush <= accept && mispred;
            if (accept && mispred) bp.redirect_pc <= act_taken ? bp.ex_target : bp.ex_pc + 32'd4;
        end
    end

`ifdef BP_STATS_EN
    // accepted control resolutions and flush-causing resolutions, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.stat_branches    <= '0;
            bp.stat_mispredicts <= '0;
        end else if (accept) begin
            if (is_br || is_jmp) bp.stat_branches <= bp.stat_branches + 32'd1;
            if (mispred) bp.stat_mispredicts <= bp.stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: doc/branch_predict.md
Name: branch_predict

Overview:
- Fetch-side direction predictor and target buffer: consumer of the branch-resolution outcome computed in execute.
- Gives fetch a same-cycle taken/target prediction per PC.
- Trains 2-bit counters and a direct-mapped BTB from execute resolutions.
- Issues a registered one-cycle flush plus redirect PC on any misprediction.

Parameters:
- ENTRIES, 64, number of BHT/BTB entries; power of two, >= 4.
- IDX_W, $clog2(ENTRIES), index width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- f_pc  input  32  fetch PC.
- f_pred_taken  output  1  prediction for f_pc.
- f_pred_target  output  32  predicted target; equals f_pc+4 when f_pred_taken=0.
- ex_valid  input  1  a resolved instruction is in execute this cycle.
- ex_pc  input  32  PC of the execute instruction.
- ex_opcode  input  7  opcode of the execute instruction.
- ex_br_taken  input  1  actual outcome from the branch-condition unit.
- ex_target  input  32  actual taken target (branch/JAL/JALR).
- ex_pred_taken  input  1  prediction made for this instruction, piped from fetch.
- ex_pred_target  input  32  target predicted for this instruction, piped from fetch.
- flush  output  1  one-cycle mispredict pulse.
- redirect_pc  output  32  correct next PC; valid while flush=1.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - Per entry: valid bit, tag, 32-bit target, 2-bit saturating counter.
- Prediction is combinational from registered state:
  - f_pred_taken = valid[idx] && tag match && ctr[idx][1].
  - Otherwise f_pred_taken=0 and f_pred_target=f_pc+4 (32-bit wrap; 0xFFFF_FFFC+4 = 0).
- Control instruction classes:
  - Branch: ex_opcode = 7'b1100011.
  - Jump: ex_opcode = 7'b1101111 (JAL) or 7'b1100111 (JALR); always taken regardless of ex_br_taken.
- Update on the rising edge when ex_valid=1 and flush=0:
  - Branch taken: ctr saturating +1 (max 2'b11); write tag and target; set valid.
  - Branch not taken: if entry hits, ctr saturating -1 (min 2'b00); otherwise no allocation.
  - Jump: write tag and target, set valid, ctr = 2'b11.
  - Any other opcode: if entry hits, clear valid (alias removal).
  - New allocation: ctr starts at 2'b10 for a taken branch, 2'b11 for a jump.
- Misprediction (evaluated on ex_* inputs, registered):
  - actual_taken = jump | (branch & ex_br_taken); non-control opcodes count as not taken.
  - Mispredict if ex_pred_taken != actual_taken, or if both are taken and ex_pred_target != ex_target.
  - On mispredict, the next edge sets flush=1 for exactly one cycle.
  - redirect_pc = actual_taken ? ex_target : ex_pc+4.
- Wrong-path suppression:
  - ex_valid is ignored in any cycle where flush=1: no update, no new flush.
  - This prevents back-to-back flushes from wrong-path instructions.
- Same-cycle hazard:
  - When the fetch index equals the index being updated, fetch sees the pre-update value; no bypass.
- Reset (asynchronous, any time, including mid-flush):
  - All valid bits 0, all ctr 2'b01, flush=0, redirect_pc=0.
  - f_pred_taken=0 immediately; f_pred_target=f_pc+4.
  - Tag and target arrays need not be reset.
- Latency:
  - Prediction: 0 cycles.
  - Training visible to fetch: 1 cycle after the ex_valid edge.
  - Flush: 1 cycle after resolution.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches counts accepted ex_valid branch/jump resolutions; stat_mispredicts counts flush-causing resolutions.
  - Both wrap at 2^32 and reset to 0 on rst_n.
  - Ignored-cycle (flush=1) events are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104, flush=0.
- Branch ex_pc=0x100, ex_br_taken=1, ex_target=0x80, ex_pred_taken=0 -> next cycle flush=1 with redirect_pc=0x80. Following cycle flush=0, and f_pc=0x100 predicts taken to 0x80 (ctr=10).
- Same branch resolved not-taken twice with ex_pred_taken matching each prediction -> ctr 10→01→00. Flush only on the first (pred taken, actual not) with redirect_pc=0x104; f_pred_taken=0 afterwards.
- JALR ex_pc=0x200, ex_target=0x300, ex_pred_taken=1, ex_pred_target=0x280 -> flush=1, redirect_pc=0x300; entry target updated to 0x300.
- Mispredict at cycle N, then ex_valid mispredict at N+1 while flush=1 -> single flush pulse, no table change at N+1. Also drive rst_n low mid-flush -> flush=0 at once, all predictions not-taken.
- Aliasing with ENTRIES=64: train 0x100 taken, then resolve ex_pc=0x200 (same idx, different tag) as a non-branch -> entry for 0x100 is unaffected. Resolve ex_pc=0x100 as a non-branch with ex_pred_taken=1 -> entry invalidated, flush with redirect_pc=0x104.
